// File: rtl/alu_defs_pkg.sv
// Shared opcodes, FSM state encoding and widths for the multi-cycle ALU.
// The optional single-cycle multiplier is selected with ALU_FAST_MUL_EN in alu_multicycle.
package alu_defs_pkg;
    localparam int ALU_OP_W = 5;

    // Bit 4 marks M-extension ops; bit 2 separates divide from multiply inside that group.
    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'd9;
    localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'd16;
    localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'd17;
    localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'd18;
    localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'd19;
    localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'd20;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'd21;
    localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'd22;
    localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;
endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative multiply (shift-add) and restoring divide on magnitudes, sharing
// one 2*XLEN accumulator; sign fix-up is applied to the final iteration's value.
module alu_muldiv_iter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] result
);
    import alu_defs_pkg::*;

    logic [2*XLEN-1:0] acc, acc_nx, prod;
    logic [XLEN-1:0]   mcand, hi, lo, raw, diff, mag_a, mag_b;
    logic [XLEN:0]     sum, shifted;
    logic [SHAMT_W-1:0] cnt;
    logic running, is_div, high, neg, sa, sb, neg_a, neg_b;

    // op[2] selects divide; op[0] clear means signed divide; op[1:0] picks the mul flavour
    always_comb begin
        sa    = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        sb    = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        neg_a = sa & a[XLEN-1];
        neg_b = sb & b[XLEN-1];
        mag_a = neg_a ? -a : a;
        mag_b = neg_b ? -b : b;
    end

    assign hi      = acc[2*XLEN-1:XLEN];
    assign lo      = acc[XLEN-1:0];
    assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    assign shifted = {hi, lo[XLEN-1]};
    // Partial remainder is always below the divisor, so the difference fits XLEN bits
    assign diff    = shifted[XLEN-1:0] - mcand;

    always_comb begin
        if (is_div)
            acc_nx = (shifted >= {1'b0, mcand}) ? {diff, lo[XLEN-2:0], 1'b1}
                                                : {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0};
        else
            acc_nx = {sum, lo[XLEN-1:1]};
        prod   = neg ? -acc_nx : acc_nx;
        raw    = high ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
        result = is_div ? (neg ? -raw : raw)
                        : (high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
    end

    assign last = running && (cnt == SHAMT_W'(XLEN-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            is_div  <= 1'b0;
            high    <= 1'b0;
            neg     <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, mag_a};
            mcand   <= mag_b;
            is_div  <= op[2];
            high    <= op[2] ? op[1] : (op[1:0] != 2'b00);
            neg     <= (op[2] && op[1]) ? neg_a : (neg_a ^ neg_b);
        end else if (running) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                running <= 1'b0;
                cnt     <= '0;
            end
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle integer ALU with RV32M mul/div behind valid/ready handshakes.
// Define ALU_FAST_MUL_EN for a native multiplier with 2-cycle MUL* latency.
module alu_multicycle
    import alu_defs_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN),
    parameter int OP_W    = ALU_OP_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_t       state;
    logic [XLEN-1:0]  base_res, special_res, md_result;
    logic [SHAMT_W-1:0] shamt;
    logic accept, is_mul, is_div, is_rem, div_special, md_start, md_last;

    assign shamt  = in_b[SHAMT_W-1:0];
    assign accept = in_valid && in_ready;
    assign is_mul = in_op inside {[ALU_MUL:ALU_MULHU]};
    assign is_div = in_op inside {[ALU_DIV:ALU_REMU]};
    assign is_rem = in_op[1];

    always_comb begin
        base_res = '0;
        case (in_op)
            ALU_ADD:  base_res = in_a + in_b;
            ALU_SUB:  base_res = in_a - in_b;
            ALU_AND:  base_res = in_a & in_b;
            ALU_OR:   base_res = in_a | in_b;
            ALU_XOR:  base_res = in_a ^ in_b;
            ALU_SLL:  base_res = in_a << shamt;
            ALU_SRL:  base_res = in_a >> shamt;
            ALU_SRA:  base_res = $signed(in_a) >>> shamt;
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, in_a < in_b};
            default:  base_res = '0;
        endcase
    end

    // Divide-by-zero and signed overflow bypass the iterative divider
    always_comb begin
        div_special = (in_b == '0) || (!in_op[0] && in_a == MIN_INT && in_b == '1);
        if (in_b == '0) special_res = is_rem ? in_a : '1;
        else            special_res = is_rem ? '0 : in_a;
    end

`ifdef ALU_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN-1:0] fprod;
    logic [2*XLEN-1:0]        prod_q;
    logic                     mul_high_q;

    assign fa       = {(in_op == ALU_MULH || in_op == ALU_MULHSU) & in_a[XLEN-1], in_a};
    assign fb       = {(in_op == ALU_MULH) & in_b[XLEN-1], in_b};
    assign fprod    = fa * fb;
    assign md_start = accept && is_div && !div_special;
`else
    assign md_start = accept && (is_mul || (is_div && !div_special));
`endif

    alu_muldiv_iter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (in_op[2:0]),
        .a      (in_a),
        .b      (in_b),
        .last   (md_last),
        .result (md_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            busy       <= 1'b0;
`ifdef ALU_FAST_MUL_EN
            prod_q     <= '0;
            mul_high_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    in_ready <= 1'b0;
                    if (is_mul) begin
                        state <= ST_MUL;
                        busy  <= 1'b1;
`ifdef ALU_FAST_MUL_EN
                        prod_q     <= fprod;
                        mul_high_q <= (in_op != ALU_MUL);
`endif
                    end else if (is_div && !div_special) begin
                        state <= ST_DIV;
                        busy  <= 1'b1;
                    end else begin
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        out_result <= is_div ? special_res : base_res;
                    end
                end
                ST_MUL: begin
`ifdef ALU_FAST_MUL_EN
                    state      <= ST_DONE;
                    busy       <= 1'b0;
                    out_valid  <= 1'b1;
                    out_result <= mul_high_q ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
`else
                    if (md_last) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                        out_result <= md_result;
                    end
`endif
                end
                ST_DIV: if (md_last) begin
                    state      <= ST_DONE;
                    busy       <= 1'b0;
                    out_valid  <= 1'b1;
                    out_result <= md_result;
                end
                ST_DONE: if (out_ready) begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
